tx_fifo_arbiter: RTL

// - REF_CLK-domain arbiter. Shares the single TX async-FIFO write port between NUM_REQ byte-stream requesters.
// - Example requesters: RegFile read response, 2-byte ALU result, status/echo frames.
// - Grants round-robin. Captures each packet whole, then pushes its bytes back-to-back under FIFO_FULL backpressure.
// - Packets are atomic: bytes of different requesters never interleave in the UART TX stream.

---
 rtl/tx_fifo_arbiter_pkg.sv | 16 +
 rtl/tx_fifo_arbiter_if.sv | 27 ++
 rtl/tx_fifo_arbiter_rr_arbiter.sv | 32 +++
 rtl/tx_fifo_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/tx_fifo_arbiter_pkg.sv
// tx_fifo_arbiter_pkg: shared widths, default parameters and FSM encodings for the TX FIFO arbiter
package tx_fifo_arbiter_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_MAX_BYTES = 2;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_e;
  function automatic int len_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction
  function automatic int id_w(input int num_req);
    return $clog2(num_req);
  endfunction
endpackage

// File: rtl/tx_fifo_arbiter_if.sv
// tx_fifo_arbiter_if: requester-side bundle plus the TX FIFO write port of the arbiter
interface tx_fifo_arbiter_if
  import tx_fifo_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MAX_BYTES = DEF_MAX_BYTES
);
  localparam int LEN_W = len_w(MAX_BYTES);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*MAX_BYTES*DATA_WIDTH-1:0] req_data;
  logic fifo_full;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [DATA_WIDTH-1:0] wr_data;
  logic wr_inc;
  logic busy;
  modport master (
    output req, req_len, req_data, fifo_full,
    input gnt, done, wr_data, wr_inc, busy
  );
  modport slave (
    input req, req_len, req_data, fifo_full,
    output gnt, done, wr_data, wr_inc, busy
  );
endinterface

// File: rtl/tx_fifo_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, with wrap
module rr_arbiter
  import tx_fifo_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win,
  output logic [$clog2(NUM_REQ)-1:0] win_id
);
  localparam int ID_W = $clog2(NUM_REQ);
  int j;
  logic [ID_W-1:0] jj;
  // scan from farthest to nearest so the nearest hit is the one left standing
  always_comb begin
    win = '0;
    win_id = '0;
    j = 0;
    jj = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      jj = ID_W'(j);
      if (req[jj]) begin
        win = '0;
        win[jj] = 1'b1;
        win_id = jj;
      end
    end
  end
endmodule

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: round-robin capture of whole packets, pushed byte-by-byte into the TX FIFO
module tx_fifo_arbiter
  import tx_fifo_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MAX_BYTES = DEF_MAX_BYTES
) (
  input logic clk,
  input logic rst,
  tx_fifo_arbiter_if.slave bus
);
  localparam int LEN_W = len_w(MAX_BYTES);
  localparam int ID_W = id_w(NUM_REQ);
  localparam int PKT_W = MAX_BYTES * DATA_WIDTH;
  state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, win_id;
  logic [NUM_REQ-1:0] win, gnt_q, gnt_d, done_q, done_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, raw_len, eff_len;
  logic [PKT_W-1:0] buf_q, buf_d, sel_data;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic wr_inc, last, capture;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(bus.req),
    .ptr(ptr_q),
    .win(win),
    .win_id(win_id)
  );

  assign raw_len = LEN_W'(bus.req_len >> (LEN_W * int'(win_id)));
  assign eff_len = raw_len == '0 ? LEN_W'(1) : raw_len > LEN_W'(MAX_BYTES) ? LEN_W'(MAX_BYTES) : raw_len;
  assign sel_data = PKT_W'(bus.req_data >> (PKT_W * int'(win_id)));
  assign last = idx_q == len_q - LEN_W'(1);
  assign capture = state_q == ST_IDLE && |bus.req;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q == ST_IDLE ? (|bus.req ? ST_SEND : ST_IDLE)
            : state_q == ST_SEND ? (wr_inc && last ? ST_IDLE : ST_SEND)
            : ST_IDLE;
  end

  always_comb begin
    wr_inc = state_q == ST_SEND && !bus.fifo_full;
    bus.wr_inc = wr_inc;
    bus.busy = state_q != ST_IDLE;
    bus.gnt = gnt_q;
    bus.done = done_q;
    bus.wr_data = wr_data_q;
  end

  // wr_data always holds the byte at idx, so the next byte is preloaded on every write
  always_comb begin
    ptr_d = ptr_q;
    id_d = id_q;
    len_d = len_q;
    idx_d = idx_q;
    buf_d = buf_q;
    gnt_d = '0;
    done_d = '0;
    wr_data_d = wr_data_q;
    if (capture) begin
      id_d = win_id;
      len_d = eff_len;
      idx_d = '0;
      buf_d = sel_data;
      gnt_d = win;
      wr_data_d = sel_data[DATA_WIDTH-1:0];
    end else if (wr_inc && last) begin
      done_d = NUM_REQ'(1) << id_q;
      ptr_d = id_q == ID_W'(NUM_REQ - 1) ? '0 : id_q + 1'b1;
    end else if (wr_inc) begin
      idx_d = idx_q + 1'b1;
      wr_data_d = DATA_WIDTH'(buf_q >> (DATA_WIDTH * (int'(idx_q) + 1)));
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q <= '0;
      id_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      buf_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      id_q <= id_d;
      len_q <= len_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      wr_data_q <= wr_data_d;
    end
endmodule
